period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter N, default 23, giving the width of the period counter and PERIOD output in bits.
REQ-002 SHALL have port CLOCK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port CLEAR  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port PULSE_IN  input  1  strobe to be measured (e.g. divided tick); rising edges are counted between.
REQ-005 SHALL have port PERIOD  output  N  last measured interval in CLOCK cycles, registered.
REQ-006 SHALL have port VALID  output  1  one-cycle pulse when PERIOD is updated.
REQ-007 SHALL have port OVERFLOW  output  1  sticky flag: interval exceeded 2**N-1 cycles.
REQ-008 SHALL have port BUSY  output  1  high while in state MEASURE.

Function
REQ-009 SHALL detect a rising edge as sampled PULSE_IN high with the previous sample low; a PULSE_IN held high SHALL count as one edge.
REQ-010 SHALL implement states IDLE (waiting for the first edge) and MEASURE (counting cycles since the last edge).
REQ-011 In IDLE, an edge SHALL set COUNT to 1 and move to MEASURE; VALID SHALL stay low.
REQ-012 In MEASURE, a cycle without an edge SHALL increment COUNT by 1.
REQ-013 In MEASURE, an edge SHALL load PERIOD with COUNT, pulse VALID for one cycle, clear OVERFLOW, set COUNT to 1 and remain in MEASURE.
REQ-014 The measured interval SHALL equal the number of CLOCK cycles between the two edge-detect cycles; a 1-cycle pulse every 4 cycles gives PERIOD=4.
REQ-015 In MEASURE, with COUNT equal to 2**N-1 and no edge, the block SHALL set OVERFLOW, leave PERIOD unchanged, keep VALID low and return to IDLE.
REQ-016 An edge arriving while COUNT equals 2**N-1 SHALL take priority over overflow and yield PERIOD=2**N-1 with VALID.
REQ-017 OVERFLOW SHALL stay set until the next VALID pulse or CLEAR.
REQ-018 COUNT arithmetic SHALL be N bits unsigned and SHALL never wrap.
REQ-019 The latency from the first CLOCK edge sampling PULSE_IN high to VALID high SHALL be 1 cycle, plus the synchronizer depth when that synchronizer is enabled.
REQ-020 BUSY SHALL be high exactly when the state is MEASURE.

Reset
REQ-021 CLEAR high at a CLOCK edge SHALL force state IDLE, COUNT=0, PERIOD=0, VALID=0, OVERFLOW=0, BUSY=0 and the edge-history register to 0.
REQ-022 CLEAR asserted mid-measurement SHALL abandon the measurement without a VALID pulse.
REQ-023 CLEAR SHALL take priority over every other event in the same cycle.
REQ-024 After CLEAR, a PULSE_IN already high SHALL count as an edge on the first cycle after reset release.

Configuration
REQ-025 Macro PERIOD_METER_SYNC_EN, when defined, SHALL insert a 2-flop synchronizer on PULSE_IN before edge detection, adding 2 cycles of latency.
REQ-026 When PERIOD_METER_SYNC_EN is undefined, PULSE_IN SHALL feed edge detection directly and SHALL be treated as synchronous to CLOCK.
REQ-027 The synchronizer flops SHALL reset to 0 on CLEAR.
REQ-028 The measured PERIOD values SHALL be identical with and without PERIOD_METER_SYNC_EN.

Structure
REQ-029 The package period_meter_pkg SHALL hold the state enum type (IDLE, MEASURE) and the synchronizer depth constant (2).
REQ-030 The optional synchronizer SHALL be the single sub-module pulse_sync, with ports CLOCK, CLEAR, D and Q.

Verification
REQ-031 N=4, 1-cycle pulse every 4 cycles -> after the first edge, VALID every 4 cycles with PERIOD=4 and BUSY=1.
REQ-032 N=4, edges 15 cycles apart -> PERIOD=15 with VALID and OVERFLOW=0 (edge wins at the boundary).
REQ-033 N=4, no edge for 16+ cycles after the first edge -> OVERFLOW=1, return to IDLE (BUSY=0), no VALID; the next two edges 5 apart -> PERIOD=5 and OVERFLOW=0.
REQ-034 PULSE_IN held high for 10 cycles, then low, then high again 12 cycles after the first rise -> a single measurement with PERIOD=12.
REQ-035 CLEAR asserted with COUNT=7 mid-measurement -> all outputs 0 the next cycle and no VALID until two new edges.
REQ-036 Both builds, with and without PERIOD_METER_SYNC_EN, driven by the REQ-031 stimulus -> the same PERIOD values, with VALID 2 cycles later when synchronized.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
// The state encoding and the synchronizer depth live here so that the top
// and the optional synchronizer agree on them.
package period_meter_pkg;

  // Measurement state: waiting for the first edge, or counting since the last.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Number of flops in the optional PULSE_IN synchronizer.
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchronizer for PULSE_IN. Used by period_meter only when
// PERIOD_METER_SYNC_EN is defined. Every stage clears to 0 on CLEAR so that
// a high input after reset is seen as a fresh rising edge downstream.
module pulse_sync
  import period_meter_pkg::*;
#(
  parameter int DEPTH = SYNC_DEPTH
) (
  input  logic CLOCK,
  input  logic CLEAR,
  input  logic D,
  output logic Q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic stage_q;
      logic stage_d;

      if (gi == 0) begin : g_first
        assign stage_d = D;
      end else begin : g_chain
        assign stage_d = g_stage[gi-1].stage_q;
      end

      // One synchronizer stage; cleared together with the rest of the block.
      always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
          stage_q <= 1'b0;
        end else begin
          stage_q <= stage_d;
        end
      end
    end
  endgenerate

  assign Q = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/period_meter.sv
// Period meter: counts CLOCK cycles between successive rising edges of
// PULSE_IN and publishes the interval on PERIOD with a one-cycle VALID.
// An interval longer than 2**N-1 cycles sets the sticky OVERFLOW flag and
// drops back to IDLE to wait for a new first edge.
// Optional build macro: PERIOD_METER_SYNC_EN inserts a 2-flop synchronizer
// (pulse_sync) on PULSE_IN; without it PULSE_IN is assumed synchronous.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int N = 23
) (
  input  logic         CLOCK,
  input  logic         CLEAR,
  input  logic         PULSE_IN,
  output logic [N-1:0] PERIOD,
  output logic         VALID,
  output logic         OVERFLOW,
  output logic         BUSY
);

  localparam logic [N-1:0] COUNT_MAX = '1;
  localparam logic [N-1:0] COUNT_ONE = N'(1);

  logic pulse_s;

`ifdef PERIOD_METER_SYNC_EN
  pulse_sync #(
    .DEPTH(SYNC_DEPTH)
  ) u_pulse_sync (
    .CLOCK(CLOCK),
    .CLEAR(CLEAR),
    .D    (PULSE_IN),
    .Q    (pulse_s)
  );
`else
  assign pulse_s = PULSE_IN;
`endif

  state_e       state_q,    state_d;
  logic [N-1:0] count_q,    count_d;
  logic [N-1:0] period_q,   period_d;
  logic         valid_q,    valid_d;
  logic         overflow_q, overflow_d;
  logic         prev_q;
  logic         edge_det;

  // A held-high input produces a single edge because prev_q follows it.
  assign edge_det = pulse_s & ~prev_q;

  // Next-state and datapath decisions; an edge always beats the overflow check.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (edge_det) begin
          count_d = COUNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          period_d   = count_q;
          valid_d    = 1'b1;
          overflow_d = 1'b0;
          count_d    = COUNT_ONE;
        end else if (count_q == COUNT_MAX) begin
          // Saturated without an edge: give up on this interval instead of wrapping.
          overflow_d = 1'b1;
          count_d    = '0;
          state_d    = IDLE;
        end else begin
          count_d = count_q + COUNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; CLEAR overrides any event in the same cycle.
  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      prev_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      prev_q     <= pulse_s;
    end
  end

  assign PERIOD   = period_q;
  assign VALID    = valid_q;
  assign OVERFLOW = overflow_q;
  assign BUSY     = (state_q == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with N=4. Stimulus is driven one input
// cycle at a time; LAT shifts each check by the synchronizer depth so the
// same expected PERIOD values hold with and without PERIOD_METER_SYNC_EN.
module tb_period_meter;

  localparam int N = 4;
`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         CLOCK = 1'b0;
  logic         CLEAR;
  logic         PULSE_IN;
  logic [N-1:0] PERIOD;
  logic         VALID;
  logic         OVERFLOW;
  logic         BUSY;

  int errors = 0;
  int checks = 0;

  period_meter #(.N(N)) dut (
    .CLOCK   (CLOCK),
    .CLEAR   (CLEAR),
    .PULSE_IN(PULSE_IN),
    .PERIOD  (PERIOD),
    .VALID   (VALID),
    .OVERFLOW(OVERFLOW),
    .BUSY    (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  // Drive one input cycle and land 1 time unit after the sampling edge.
  task automatic step(input logic p);
    PULSE_IN = p;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    CLEAR    = 1'b1;
    PULSE_IN = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("rst_period",   int'(PERIOD),   0);
    chk("rst_valid",    int'(VALID),    0);
    chk("rst_overflow", int'(OVERFLOW), 0);
    chk("rst_busy",     int'(BUSY),     0);
    $display("txn reset: PERIOD=%0d VALID=%0d OVERFLOW=%0d BUSY=%0d", PERIOD, VALID, OVERFLOW, BUSY);
    CLEAR = 1'b0;
    step(1'b0);
    step(1'b0);

    // Pulse every 4 cycles: first edge only arms, then PERIOD=4 each time.
    step(1'b1);
    repeat (LAT) step(1'b0);
    chk("p4_first_busy",  int'(BUSY),  1);
    chk("p4_first_valid", int'(VALID), 0);
    repeat (3 - LAT) step(1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      repeat (LAT) step(1'b0);
      chk("p4_valid",  int'(VALID),  1);
      chk("p4_period", int'(PERIOD), 4);
      chk("p4_busy",   int'(BUSY),   1);
      $display("txn p4[%0d]: PERIOD=%0d VALID=%0d BUSY=%0d", k, PERIOD, VALID, BUSY);
      step(1'b0);
      chk("p4_valid_drop", int'(VALID), 0);
      repeat (2 - LAT) step(1'b0);
    end

    // Edges 15 cycles apart: edge wins over overflow at COUNT=15.
    repeat (11) step(1'b0);
    step(1'b1);
    repeat (LAT) step(1'b0);
    chk("p15_valid",    int'(VALID),    1);
    chk("p15_period",   int'(PERIOD),   15);
    chk("p15_overflow", int'(OVERFLOW), 0);
    $display("txn p15: PERIOD=%0d VALID=%0d OVERFLOW=%0d", PERIOD, VALID, OVERFLOW);

    // No edge for 16 cycles: overflow, back to IDLE, PERIOD held.
    repeat (14) step(1'b0);
    chk("ovf_pre_flag", int'(OVERFLOW), 0);
    chk("ovf_pre_busy", int'(BUSY),     1);
    step(1'b0);
    chk("ovf_flag",   int'(OVERFLOW), 1);
    chk("ovf_busy",   int'(BUSY),     0);
    chk("ovf_valid",  int'(VALID),    0);
    chk("ovf_period", int'(PERIOD),   15);
    $display("txn overflow: PERIOD=%0d OVERFLOW=%0d BUSY=%0d", PERIOD, OVERFLOW, BUSY);
    repeat (3) step(1'b0);
    chk("ovf_sticky", int'(OVERFLOW), 1);
    step(1'b1);
    repeat (LAT) step(1'b0);
    chk("ovf_rearm_busy",  int'(BUSY),     1);
    chk("ovf_rearm_valid", int'(VALID),    0);
    chk("ovf_rearm_flag",  int'(OVERFLOW), 1);
    repeat (4 - LAT) step(1'b0);
    step(1'b1);
    repeat (LAT) step(1'b0);
    chk("p5_valid",    int'(VALID),    1);
    chk("p5_period",   int'(PERIOD),   5);
    chk("p5_overflow", int'(OVERFLOW), 0);
    $display("txn p5: PERIOD=%0d VALID=%0d OVERFLOW=%0d", PERIOD, VALID, OVERFLOW);

    // Held-high input: one rise, held 10 cycles, next rise 12 cycles later.
    CLEAR = 1'b1;
    step(1'b0);
    CLEAR = 1'b0;
    step(1'b0);
    step(1'b1);
    repeat (9) step(1'b1);
    chk("hold_valid", int'(VALID), 0);
    chk("hold_busy",  int'(BUSY),  1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    repeat (LAT) step(1'b1);
    chk("p12_valid",  int'(VALID),  1);
    chk("p12_period", int'(PERIOD), 12);
    $display("txn p12: PERIOD=%0d VALID=%0d", PERIOD, VALID);
    step(1'b1);
    chk("p12_held_valid", int'(VALID), 0);

    // CLEAR with COUNT=7 mid-measurement abandons it.
    step(1'b0);
    step(1'b0);
    step(1'b1);
    repeat (6 + LAT) step(1'b0);
    CLEAR = 1'b1;
    step(1'b0);
    CLEAR = 1'b0;
    chk("clr_period",   int'(PERIOD),   0);
    chk("clr_valid",    int'(VALID),    0);
    chk("clr_overflow", int'(OVERFLOW), 0);
    chk("clr_busy",     int'(BUSY),     0);
    $display("txn clear: PERIOD=%0d VALID=%0d OVERFLOW=%0d BUSY=%0d", PERIOD, VALID, OVERFLOW, BUSY);
    step(1'b0);
    step(1'b1);
    repeat (LAT) step(1'b0);
    chk("clr_first_valid", int'(VALID), 0);
    chk("clr_first_busy",  int'(BUSY),  1);
    repeat (5 - LAT) step(1'b0);
    step(1'b1);
    repeat (LAT) step(1'b0);
    chk("p6_valid",  int'(VALID),  1);
    chk("p6_period", int'(PERIOD), 6);
    $display("txn p6: PERIOD=%0d VALID=%0d", PERIOD, VALID);

    // CLEAR beats a coincident edge; a high input after release is an edge.
    step(1'b0);
    step(1'b0);
    CLEAR = 1'b1;
    step(1'b1);
    chk("clrpri_period", int'(PERIOD), 0);
    chk("clrpri_valid",  int'(VALID),  0);
    chk("clrpri_busy",   int'(BUSY),   0);
    CLEAR = 1'b0;
    step(1'b1);
    repeat (LAT) step(1'b1);
    chk("post_clr_busy",  int'(BUSY),  1);
    chk("post_clr_valid", int'(VALID), 0);
    $display("txn post_clear: BUSY=%0d VALID=%0d", BUSY, VALID);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
